split_arbiter: RTL and testbench
================================

SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = round-robin between masters on simultaneous requests; 0 = fixed priority, m1 wins.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 m1_breq  in  1  master 1 bus request; held high for whole transaction.
REQ-005 m2_breq  in  1  master 2 bus request; held high for whole transaction.
REQ-006 s_split  in  1  one-cycle pulse from the addressed slave: split the current transaction.
REQ-007 s_split_ready  in  1  split slave ready to resume the parked transaction; level.
REQ-008 m1_bgrant  out  1  master 1 owns bus.
REQ-009 m2_bgrant  out  1  master 2 owns bus.
REQ-010 msel  out  1  bus master mux select: 0 = m1, 1 = m2; holds last owner when idle.
REQ-011 m1_split  out  1  master 1 transaction parked by split.
REQ-012 m2_split  out  1  master 2 transaction parked by split.
REQ-013 split_grant  out  1  current grant is a resumed split transaction; bus routes to split slave.

Function
REQ-014 All outputs registered; states IDLE, GNT_M1, GNT_M2; side registers split_pend (0/1), split_mst (1 bit), last_gnt (1 bit).
REQ-015 Grant latency: request sampled high at edge N while IDLE -> grant high from edge N+1; no combinational path from any input to any output.
REQ-016 Effective request: mX_breq AND NOT (split_pend AND split_mst == X); a parked master's request is masked.
REQ-017 IDLE, one effective request -> grant that master; both -> ROUND_ROBIN=1: master != last_gnt; ROUND_ROBIN=0: m1.
REQ-018 GNT_Mx held while mx_breq high; no preemption by any input.
REQ-019 GNT_Mx with mx_breq low -> zero-bubble handover: next state chosen by REQ-017/REQ-022 rules in the same edge, else IDLE.
REQ-020 last_gnt updated to X on every entry into GNT_Mx.
REQ-021 GNT_Mx with s_split=1 and split_pend=0 -> mx_bgrant low next cycle, mx_split high, split_pend=1, split_mst=X, then arbitrate the other master per REQ-019 (takes priority over mx_breq low in the same cycle).
REQ-022 Resume: split_pend=1 and s_split_ready=1 and state IDLE or releasing -> grant split_mst with split_grant=1, clear mx_split and split_pend same edge; resume beats any new request.
REQ-023 s_split_ready while other master owns bus -> wait until release; no preemption.
REQ-024 split_grant stays high for the duration of the resumed grant; it clears when that master releases.
REQ-025 s_split while split_pend=1, while IDLE, or while split_grant=1 -> ignored.
REQ-026 s_split_ready with split_pend=0 -> ignored; s_split and s_split_ready in the same cycle -> split taken, ready ignored that cycle.
REQ-027 Invariants: at most one of m1_bgrant/m2_bgrant high; mx_split and mx_bgrant never both high.

Reset
REQ-028 rstn low at edge -> state IDLE, all grants 0, m1_split=m2_split=0, split_grant=0, split_pend=0, msel=0, last_gnt=m2 (m1 first winner under round-robin).
REQ-029 Reset mid-transaction or with split pending aborts all; grants drop the cycle after the reset edge; no request is remembered.

Verification
REQ-030 Reset then m1_breq=1 at edge 3 -> m1_bgrant=1, msel=0 from edge 4; m2 stays 0.
REQ-031 ROUND_ROBIN=1, both breq held, each owner drops breq after 4 grant cycles and re-raises it -> grants alternate m1,m2,m1 with zero idle cycles between them.
REQ-032 ROUND_ROBIN=0, both breq held -> m1 re-granted each time it releases and re-requests; m2 granted only when m1_breq is low.
REQ-033 m1 granted, s_split pulse, m2_breq=1 -> next cycle m1_bgrant=0, m1_split=1, m2_bgrant=1, msel=1; m1_breq high is ignored.
REQ-034 Continuing: s_split_ready=1 while m2 owns the bus, then m2 drops breq -> next cycle m1_bgrant=1, split_grant=1, m1_split=0; a concurrent m2 re-request waits.
REQ-035 rstn low while split pending and m2 granted -> all outputs return to REQ-028 values the next cycle; a later s_split_ready alone produces no grant.

Source files
------------

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with split-transaction support: a slave may park the
// current owner's transaction and later resume it ahead of any new request.
module split_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic s_split,
  input  logic s_split_ready,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic m1_split,
  output logic m2_split,
  output logic split_grant
);

  typedef enum logic [1:0] {IDLE, GNT_M1, GNT_M2} state_t;

  state_t state, state_n;
  logic   split_pend, split_pend_n;
  logic   split_mst, split_mst_n;   // 0 = m1, 1 = m2
  logic   last_gnt, last_gnt_n;     // 0 = m1, 1 = m2
  logic   msel_n, m1_split_n, m2_split_n, split_grant_n;
  logic   arb;
  logic   req1_eff, req2_eff;

  // A parked master's request is masked until its transaction resumes
  assign req1_eff = m1_breq & ~(split_pend & ~split_mst);
  assign req2_eff = m2_breq & ~(split_pend & split_mst);

  // State and all outputs registered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      split_pend  <= 1'b0;
      split_mst   <= 1'b0;
      last_gnt    <= 1'b1;
      msel        <= 1'b0;
      m1_split    <= 1'b0;
      m2_split    <= 1'b0;
      split_grant <= 1'b0;
      m1_bgrant   <= 1'b0;
      m2_bgrant   <= 1'b0;
    end else begin
      state       <= state_n;
      split_pend  <= split_pend_n;
      split_mst   <= split_mst_n;
      last_gnt    <= last_gnt_n;
      msel        <= msel_n;
      m1_split    <= m1_split_n;
      m2_split    <= m2_split_n;
      split_grant <= split_grant_n;
      m1_bgrant   <= (state_n == GNT_M1);
      m2_bgrant   <= (state_n == GNT_M2);
    end
  end

  // Next-state and output decisions
  always_comb begin
    state_n       = state;
    split_pend_n  = split_pend;
    split_mst_n   = split_mst;
    last_gnt_n    = last_gnt;
    msel_n        = msel;
    m1_split_n    = m1_split;
    m2_split_n    = m2_split;
    split_grant_n = split_grant;
    arb           = 1'b0;

    case (state)
      IDLE: arb = 1'b1;
      GNT_M1: begin
        if (s_split && !split_pend && !split_grant) begin
          m1_split_n   = 1'b1;
          split_pend_n = 1'b1;
          split_mst_n  = 1'b0;
          state_n      = m2_breq ? GNT_M2 : IDLE;
        end else if (!m1_breq) begin
          arb = 1'b1;
        end
      end
      GNT_M2: begin
        if (s_split && !split_pend && !split_grant) begin
          m2_split_n   = 1'b1;
          split_pend_n = 1'b1;
          split_mst_n  = 1'b1;
          state_n      = m1_breq ? GNT_M1 : IDLE;
        end else if (!m2_breq) begin
          arb = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Resume of a parked transaction beats any new request
    if (arb) begin
      state_n       = IDLE;
      split_grant_n = 1'b0;
      if (split_pend && s_split_ready) begin
        state_n       = split_mst ? GNT_M2 : GNT_M1;
        split_grant_n = 1'b1;
        split_pend_n  = 1'b0;
        if (split_mst) m2_split_n = 1'b0;
        else           m1_split_n = 1'b0;
      end else if (req1_eff && req2_eff) begin
        state_n = (ROUND_ROBIN ? ~last_gnt : 1'b0) ? GNT_M2 : GNT_M1;
      end else if (req1_eff) begin
        state_n = GNT_M1;
      end else if (req2_eff) begin
        state_n = GNT_M2;
      end
    end

    if (state_n == GNT_M1) begin
      last_gnt_n = 1'b0;
      msel_n     = 1'b0;
    end else if (state_n == GNT_M2) begin
      last_gnt_n = 1'b1;
      msel_n     = 1'b1;
    end
  end

endmodule

// File: tb/tb_split_arbiter.sv
// Directed self-checking bench for split_arbiter; a round-robin and a
// fixed-priority instance share the same stimulus.
module tb_split_arbiter;

  logic clk = 1'b0;
  logic rstn, m1_breq, m2_breq, s_split, s_split_ready;
  logic rr_m1g, rr_m2g, rr_msel, rr_m1s, rr_m2s, rr_sg;
  logic fp_m1g, fp_m2g, fp_msel, fp_m1s, fp_m2s, fp_sg;
  logic [5:0] rr_out, fp_out;
  int checks = 0;
  int errors = 0;

  // Observed vector order: {m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant}
  assign rr_out = {rr_m1g, rr_m2g, rr_msel, rr_m1s, rr_m2s, rr_sg};
  assign fp_out = {fp_m1g, fp_m2g, fp_msel, fp_m1s, fp_m2s, fp_sg};

  always #5 clk = ~clk;

  split_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .s_split(s_split), .s_split_ready(s_split_ready),
    .m1_bgrant(rr_m1g), .m2_bgrant(rr_m2g), .msel(rr_msel),
    .m1_split(rr_m1s), .m2_split(rr_m2s), .split_grant(rr_sg)
  );

  split_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .s_split(s_split), .s_split_ready(s_split_ready),
    .m1_bgrant(fp_m1g), .m2_bgrant(fp_m2g), .msel(fp_msel),
    .m1_split(fp_m1s), .m2_split(fp_m2s), .split_grant(fp_sg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0; s_split = 1'b0; s_split_ready = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (rr_out !== 6'b000000) begin errors++; $display("FAIL reset_rr: got %b expected %b", rr_out, 6'b000000); end
    checks++;
    if (fp_out !== 6'b000000) begin errors++; $display("FAIL reset_fp: got %b expected %b", fp_out, 6'b000000); end
  endtask

  task automatic test_grant_latency();
    m1_breq = 1'b1;
    #1;
    checks++;
    if (rr_out !== 6'b000000) begin errors++; $display("FAIL latency_comb: got %b expected %b", rr_out, 6'b000000); end
    step();
    checks++;
    if (rr_out !== 6'b100000) begin errors++; $display("FAIL latency_grant: got %b expected %b", rr_out, 6'b100000); end
    m1_breq = 1'b0;
    step();
    checks++;
    if (rr_out !== 6'b000000) begin errors++; $display("FAIL latency_release: got %b expected %b", rr_out, 6'b000000); end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp;
    do_reset();
    m1_breq = 1'b1; m2_breq = 1'b1;
    step();
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 6'b100000 : 6'b011000;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (rr_out !== exp) begin errors++; $display("FAIL rr_owner%0d_cyc%0d: got %b expected %b", g, c, rr_out, exp); end
        if (c < 3) step();
      end
      if (g % 2 == 0) m1_breq = 1'b0; else m2_breq = 1'b0;
      step();
      if (g % 2 == 0) m1_breq = 1'b1; else m2_breq = 1'b1;
    end
    m1_breq = 1'b0; m2_breq = 1'b0;
    step();
  endtask

  task automatic test_fixed_priority();
    logic [5:0] fp_exp [9];
    logic [1:0] req [9];
    fp_exp = '{6'b100000, 6'b000000, 6'b100000, 6'b000000, 6'b100000,
               6'b011000, 6'b011000, 6'b100000, 6'b000000};
    req    = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      m1_breq = req[i][1]; m2_breq = req[i][0];
      step();
      checks++;
      if (fp_out !== fp_exp[i]) begin errors++; $display("FAIL fp_step%0d: got %b expected %b", i, fp_out, fp_exp[i]); end
      if (i == 2) begin
        checks++;
        if (rr_out !== 6'b011000) begin errors++; $display("FAIL rr_vs_fp_step2: got %b expected %b", rr_out, 6'b011000); end
      end
    end
  endtask

  task automatic test_split();
    logic [5:0] exp [12];
    logic [3:0] in [12];  // {m1_breq, m2_breq, s_split, s_split_ready}
    in  = '{4'b1000, 4'b1110, 4'b1100, 4'b1101, 4'b1001, 4'b1100,
            4'b1110, 4'b0100, 4'b0111, 4'b0100, 4'b0101, 4'b0000};
    exp = '{6'b100000, 6'b011100, 6'b011100, 6'b011100, 6'b100001, 6'b100001,
            6'b100001, 6'b011000, 6'b001010, 6'b001010, 6'b011001, 6'b001000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      {m1_breq, m2_breq, s_split, s_split_ready} = in[i];
      step();
      checks++;
      if (rr_out !== exp[i]) begin errors++; $display("FAIL split_step%0d: got %b expected %b", i, rr_out, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_split();
    do_reset();
    m1_breq = 1'b1;
    step();
    m2_breq = 1'b1; s_split = 1'b1;
    step();
    s_split = 1'b0;
    checks++;
    if (rr_out !== 6'b011100) begin errors++; $display("FAIL rst_split_setup: got %b expected %b", rr_out, 6'b011100); end
    rstn = 1'b0;
    step();
    checks++;
    if (rr_out !== 6'b000000) begin errors++; $display("FAIL rst_split_abort: got %b expected %b", rr_out, 6'b000000); end
    rstn = 1'b1; m1_breq = 1'b0; m2_breq = 1'b0; s_split_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rr_out !== 6'b000000) begin errors++; $display("FAIL rst_ready_ignored%0d: got %b expected %b", i, rr_out, 6'b000000); end
    end
    s_split_ready = 1'b0; s_split = 1'b1;
    step();
    s_split = 1'b0;
    checks++;
    if (rr_out !== 6'b000000) begin errors++; $display("FAIL idle_split_ignored: got %b expected %b", rr_out, 6'b000000); end
  endtask

  initial begin
    rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0; s_split = 1'b0; s_split_ready = 1'b0;
    test_reset();
    test_grant_latency();
    test_round_robin();
    test_fixed_priority();
    test_split();
    test_reset_mid_split();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
